// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM, one-entry skid buffer
// for responses that arrive while ID is stalled, and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IBranchTarget,
  input  logic        CBranchTaken,
  input  logic        CStall,
  input  logic        CFlush,
  output logic        OImemReq,
  output logic [31:0] OImemAddr,
  input  logic [31:0] IImemRdata,
  input  logic        IImemValid,
  output logic [31:0] OInstr,
  output logic [31:0] OPC,
  output logic [31:0] OPCPlus4,
  output logic        OValid
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] buf_data;
  logic [31:0] buf_pc;
  logic        buf_full;

  logic        resp_ok;
  logic        issue_cond;
  logic        buf_drain;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  always_comb begin
    resp_ok    = (state == WAIT) && IImemValid;
    buf_drain  = (state == IDLE) && buf_full && !CStall;
    issue_cond = ((state == IDLE) && (!buf_full || !CStall)) || (resp_ok && !CStall);
  end

  assign OImemReq  = reset && issue_cond && !CBranchTaken;
  assign OImemAddr = pc;

  // Fetch control and IF/ID register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_pc   <= 32'd0;
      buf_full <= 1'b0;
      OInstr   <= 32'd0;
      OPC      <= 32'd0;
      OPCPlus4 <= 32'd0;
      OValid   <= 1'b0;
    end else if (CBranchTaken) begin
      // Any response landing this cycle belongs to the wrong path and is dropped;
      // a still-outstanding one is swallowed later in DROP.
      pc       <= word_align(IBranchTarget);
      buf_full <= 1'b0;
      OValid   <= 1'b0;
      if ((state == WAIT || state == DROP) && !IImemValid)
        state <= DROP;
      else
        state <= IDLE;
    end else begin
      if (OImemReq) begin
        req_pc <= pc;
        pc     <= next_word(pc);
        state  <= WAIT;
      end else if (resp_ok && CStall) begin
        state <= IDLE;
      end else if (state == DROP && IImemValid) begin
        state <= IDLE;
      end

      if (resp_ok && CStall)
        buf_full <= 1'b1;
      else if (buf_drain)
        buf_full <= 1'b0;

      if (CFlush) begin
        OValid <= 1'b0;
      end else if (!CStall) begin
        if (resp_ok) begin
          OInstr   <= IImemRdata;
          OPC      <= req_pc;
          OPCPlus4 <= next_word(req_pc);
          OValid   <= 1'b1;
        end else if (buf_full) begin
          OInstr   <= buf_data;
          OPC      <= buf_pc;
          OPCPlus4 <= next_word(buf_pc);
          OValid   <= 1'b1;
        end else begin
          OValid <= 1'b0;
        end
      end
    end
  end

  // Skid buffer payload; qualified by buf_full so it needs no reset
  always_ff @(posedge clk) begin
    if (resp_ok && CStall) begin
      buf_data <= IImemRdata;
      buf_pc   <= req_pc;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector tables driven against a
// latency-configurable instruction memory model that returns the address as data.
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] IBranchTarget;
  logic        CBranchTaken;
  logic        CStall;
  logic        CFlush;
  logic        OImemReq;
  logic [31:0] OImemAddr;
  logic [31:0] IImemRdata;
  logic        IImemValid;
  logic [31:0] OInstr;
  logic [31:0] OPC;
  logic [31:0] OPCPlus4;
  logic        OValid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic        w_valid;

  if_stage dut (
    .clk(clk), .reset(reset), .IBranchTarget(IBranchTarget),
    .CBranchTaken(CBranchTaken), .CStall(CStall), .CFlush(CFlush),
    .OImemReq(OImemReq), .OImemAddr(OImemAddr), .IImemRdata(IImemRdata),
    .IImemValid(IImemValid), .OInstr(OInstr), .OPC(OPC), .OPCPlus4(OPCPlus4),
    .OValid(OValid)
  );

  // Same control inputs as dut; its behaviour differs only by the start address.
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .IBranchTarget(IBranchTarget),
    .CBranchTaken(CBranchTaken), .CStall(CStall), .CFlush(CFlush),
    .OImemReq(w_req), .OImemAddr(w_addr), .IImemRdata(IImemRdata),
    .IImemValid(IImemValid), .OInstr(w_instr), .OPC(w_pc), .OPCPlus4(w_pc4),
    .OValid(w_valid)
  );

  typedef struct {
    bit          stall;
    bit          flush;
    bit          br;
    logic [31:0] tgt;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    bit          wchk;
    logic [31:0] exp_waddr;
  } vec_t;

  vec_t vecs[$];

  int tests = 0;
  int fails = 0;

  int          lat;
  int          cnt;
  bit          pend;
  logic [31:0] maddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input bit s, input bit f, input bit b, input logic [31:0] t,
                              input bit rq, input logic [31:0] a, input bit v,
                              input logic [31:0] p, input bit wc, input logic [31:0] wa);
    vec_t r;
    r.stall = s; r.flush = f; r.br = b; r.tgt = t;
    r.exp_req = rq; r.exp_addr = a; r.exp_valid = v; r.exp_pc = p;
    r.wchk = wc; r.exp_waddr = wa;
    vecs.push_back(r);
  endfunction

  // One clock edge; the memory model sees the request that was present before it.
  task automatic tick();
    bit          r;
    logic [31:0] a;
    r = OImemReq;
    a = OImemAddr;
    @(posedge clk);
    #1;
    if (IImemValid) begin
      IImemValid = 1'b0;
      pend = 1'b0;
    end
    if (r) begin
      pend  = 1'b1;
      cnt   = lat;
      maddr = a;
    end else if (pend) begin
      cnt--;
    end
    IImemValid = pend && (cnt == 1);
    IImemRdata = IImemValid ? maddr : 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    CStall = 1'b0; CFlush = 1'b0; CBranchTaken = 1'b0; IBranchTarget = 32'd0;
    pend = 1'b0; cnt = 0; IImemValid = 1'b0; IImemRdata = 32'd0;
    tick();
    tick();
    check("rst_req", {31'd0, OImemReq}, 32'd0);
    check("rst_valid", {31'd0, OValid}, 32'd0);
    check("rst_instr", OInstr, 32'd0);
    check("rst_pc", OPC, 32'd0);
    check("rst_pc4", OPCPlus4, 32'd0);
    reset = 1'b1;
  endtask

  task automatic run(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      CStall        = vecs[i].stall;
      CFlush        = vecs[i].flush;
      CBranchTaken  = vecs[i].br;
      IBranchTarget = vecs[i].tgt;
      #1;
      check($sformatf("%s[%0d] req", tag, i), {31'd0, OImemReq}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        check($sformatf("%s[%0d] addr", tag, i), OImemAddr, vecs[i].exp_addr);
      check($sformatf("%s[%0d] valid", tag, i), {31'd0, OValid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("%s[%0d] pc", tag, i), OPC, vecs[i].exp_pc);
        check($sformatf("%s[%0d] pc4", tag, i), OPCPlus4, vecs[i].exp_pc + 32'd4);
        check($sformatf("%s[%0d] instr", tag, i), OInstr, vecs[i].exp_pc);
      end
      if (vecs[i].wchk)
        check($sformatf("%s[%0d] wrap_addr", tag, i), w_addr, vecs[i].exp_waddr);
      tick();
    end
    vecs.delete();
  endtask

  initial begin
    // Streaming with a 3-cycle stall while the response for 0x8 arrives
    lat = 1;
    do_reset();
    //   s  f  b  tgt     req addr       v  pc     wchk waddr
    add(0, 0, 0, 32'h0, 1, 32'h00, 0, 32'h00, 1, 32'hFFFF_FFFC);
    add(0, 0, 0, 32'h0, 1, 32'h04, 0, 32'h00, 1, 32'h0000_0000);
    add(0, 0, 0, 32'h0, 1, 32'h08, 1, 32'h00, 0, 32'h0);
    add(1, 0, 0, 32'h0, 0, 32'h00, 1, 32'h04, 0, 32'h0);
    add(1, 0, 0, 32'h0, 0, 32'h00, 1, 32'h04, 0, 32'h0);
    add(1, 0, 0, 32'h0, 0, 32'h00, 1, 32'h04, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1, 32'h0C, 1, 32'h04, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1, 32'h10, 1, 32'h08, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1, 32'h14, 1, 32'h0C, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1, 32'h18, 1, 32'h10, 0, 32'h0);
    run("stream");

    // 3-cycle memory: branch while the fetch of 0x10 is in flight
    lat = 3;
    do_reset();
    add(0, 0, 1, 32'h13,  0, 32'h000, 0, 32'h0, 0, 32'h0);
    add(0, 0, 0, 32'h0,   1, 32'h010, 0, 32'h0, 0, 32'h0);
    add(0, 0, 1, 32'h100, 0, 32'h000, 0, 32'h0, 0, 32'h0);
    add(0, 0, 0, 32'h0,   0, 32'h000, 0, 32'h0, 0, 32'h0);
    add(0, 0, 0, 32'h0,   0, 32'h000, 0, 32'h0, 0, 32'h0);
    add(0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0, 0, 32'h0);
    add(0, 0, 0, 32'h0,   0, 32'h000, 0, 32'h0, 0, 32'h0);
    add(0, 0, 0, 32'h0,   0, 32'h000, 0, 32'h0, 0, 32'h0);
    add(0, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0, 0, 32'h0);
    add(0, 0, 0, 32'h0,   0, 32'h000, 1, 32'h100, 0, 32'h0);
    run("drop");

    // Branch in the same cycle as a response; unaligned target
    lat = 1;
    do_reset();
    add(0, 0, 0, 32'h0,   1, 32'h000, 0, 32'h0,   0, 32'h0);
    add(0, 0, 1, 32'h103, 0, 32'h000, 0, 32'h0,   0, 32'h0);
    add(0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   0, 32'h0);
    add(0, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0,   0, 32'h0);
    add(0, 0, 0, 32'h0,   1, 32'h108, 1, 32'h100, 0, 32'h0);
    run("brresp");

    // Flush during a stall: bubble only, fetch state intact
    do_reset();
    add(0, 0, 0, 32'h0, 1, 32'h00, 0, 32'h00, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1, 32'h04, 0, 32'h00, 0, 32'h0);
    add(1, 1, 0, 32'h0, 0, 32'h00, 1, 32'h00, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1, 32'h08, 0, 32'h00, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1, 32'h0C, 1, 32'h04, 0, 32'h0);
    add(0, 0, 0, 32'h0, 1, 32'h10, 1, 32'h08, 0, 32'h0);
    run("flush");

    // Reset while a 3-cycle fetch is outstanding: its response must be ignored
    lat = 3;
    do_reset();
    #1;
    check("rstpend_req0", {31'd0, OImemReq}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check("rstpend_req_in_reset", {31'd0, OImemReq}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rstpend_resp_present", {31'd0, IImemValid}, 32'd1);
    check("rstpend_req", {31'd0, OImemReq}, 32'd1);
    check("rstpend_addr", OImemAddr, 32'd0);
    tick();
    check("rstpend_valid", {31'd0, OValid}, 32'd0);
    check("rstpend_addr_next", OImemAddr, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
